console_xbar: RTL and testbench
===============================

# console_xbar

Registered, glitch-free console crossbar: routes any of INPUT_COUNT asynchronous serial lines to each of OUTPUT_COUNT outputs through per-output selectors and enables. It succeeds the combinational selector mux. Each output channel changes source only after the old source has been quiet, then drives a guaranteed idle gap. Reconfiguration is atomic across all outputs through a valid/ready handshake, so a UART frame in flight is never chopped or spliced.

## Interface
- INPUT_COUNT, 4, number of input lines
- OUTPUT_COUNT, 4, number of output channels
- SEL_WIDTH, 4, selector bits per output; 2**SEL_WIDTH >= INPUT_COUNT
- SYNC_STAGES, 2, input synchroniser depth; >= 2
- IDLE_LEVEL, 1, line idle/mark level driven on disabled or switching outputs
- QUIET_CYCLES, 16, consecutive idle cycles on the old source required before switching; >= 1
- GAP_CYCLES, 4, cycles of forced idle between old and new source; >= 1
- MAX_DRAIN, 4096, drain timeout in cycles; >= QUIET_CYCLES

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in  in  INPUT_COUNT  asynchronous input lines
- cfg_sel  in  OUTPUT_COUNT*SEL_WIDTH  requested selector; output k uses bits [k*SEL_WIDTH +: SEL_WIDTH]
- cfg_en  in  OUTPUT_COUNT  requested per-output enable
- cfg_valid  in  1  request config write
- cfg_ready  out  1  config can be accepted; equals ~|busy
- out  out  OUTPUT_COUNT  registered routed lines
- active_sel  out  OUTPUT_COUNT*SEL_WIDTH  selector currently in effect
- active_en  out  OUTPUT_COUNT  enable currently in effect
- busy  out  OUTPUT_COUNT  channel in DRAIN or GAP
- forced  out  OUTPUT_COUNT  sticky: last switch on channel ended by timeout

## Operation
- Reset: synchroniser flops = IDLE_LEVEL; active_sel = 0, active_en = 0, out = all IDLE_LEVEL, busy = 0, forced = 0, cfg_ready = 1. Reset asserted mid-switch aborts it; the pending config is discarded.
- Handshake: config accepted on a clk edge with cfg_valid && cfg_ready. cfg_valid while busy is not accepted; the source holds the request. An accepted config clears all forced bits.
- Channel k is "changed" when requested {sel,en} differs from active {sel,en}. Two disabled requests compare equal regardless of sel. Unchanged channels are not disturbed. A config identical to the active one is accepted and no busy rises.
- Effective source: active_en[k] && active_sel[k] < INPUT_COUNT selects that synchronised input. Otherwise the channel is off and drives IDLE_LEVEL; an out-of-range selector counts as off.
- Per-channel FSM:
  - ACTIVE: out follows effective source. On accept of a changed config → DRAIN, or → GAP directly if the channel is currently off.
  - DRAIN: out still follows the old source. A quiet counter increments on each cycle the old synced source == IDLE_LEVEL and resets to 0 otherwise. Reaching QUIET_CYCLES → GAP. A total-drain counter reaching MAX_DRAIN → GAP with forced[k]=1.
  - GAP: out = IDLE_LEVEL for GAP_CYCLES cycles, then load the pending {sel,en} into active and → ACTIVE.
- Counters are wide enough for MAX_DRAIN and do not wrap.

## Timing
- Input to out latency: SYNC_STAGES + 1 cycles in ACTIVE.
- Accept at edge N, with the old source idle throughout:
  - busy[k] = 1 from N+1.
  - DRAIN spans cycles N+1..N+QUIET_CYCLES.
  - GAP spans the next GAP_CYCLES cycles.
  - active_sel/active_en update and busy[k] falls at N+QUIET_CYCLES+GAP_CYCLES+1.
  - out shows the new source one cycle later.
- Channel already off at accept: GAP spans N+1..N+GAP_CYCLES.
- cfg_ready is combinational from busy. It rises the cycle the last busy channel returns to ACTIVE, so a back-to-back config may be accepted on that edge.
- out never carries an old-source bit after the first GAP cycle and never glitches within a cycle (registered).

## Test plan
Default bench parameters: 4/4, SEL_WIDTH 4, QUIET 4, GAP 2, MAX_DRAIN 32.

- Reset, then in=4'b1010: out = 4'b1111, cfg_ready=1, active_en=0, busy=0.
- Accept sel0=2, en=4'b0001 on idle lines: busy[0] for 2 cycles, then active_sel[3:0]=2. After that, toggling in[2] appears on out[0] 3 cycles later; out[3:1] stay 1.
- Switch out[0] from 2 to 3 while in[2] toggles every 3 cycles, then holds high:
  - DRAIN persists until 4 consecutive high cycles.
  - Then out[0]=1 for exactly 2 cycles before following in[3].
  - cfg_valid held during busy is not accepted until cfg_ready=1.
- in[2] stuck low, switch out[0]: timeout after 32 DRAIN cycles, forced[0]=1. The next accepted config clears forced[0].
- Config with sel1=7 (out of range), en1=1: out[1] = 1 after switch. Resubmitting the identical config is accepted in one cycle with busy=0.
- Assert rst mid-GAP: next cycle all outputs at reset values, pending config lost.

Source files
------------

// File: rtl/console_xbar_if.sv
// Signal bundle for the console crossbar: serial lines, the config handshake and channel status.
// The bench holds the master side and the crossbar holds the slave side.
interface console_xbar_if #(
  parameter int INPUT_COUNT  = 4,
  parameter int OUTPUT_COUNT = 4,
  parameter int SEL_WIDTH    = 4
);
  logic [INPUT_COUNT-1:0]            in;
  logic [OUTPUT_COUNT*SEL_WIDTH-1:0] cfg_sel;
  logic [OUTPUT_COUNT-1:0]           cfg_en;
  logic                              cfg_valid;
  logic                              cfg_ready;
  logic [OUTPUT_COUNT-1:0]           out;
  logic [OUTPUT_COUNT*SEL_WIDTH-1:0] active_sel;
  logic [OUTPUT_COUNT-1:0]           active_en;
  logic [OUTPUT_COUNT-1:0]           busy;
  logic [OUTPUT_COUNT-1:0]           forced;

  modport master (
    output in, cfg_sel, cfg_en, cfg_valid,
    input  cfg_ready, out, active_sel, active_en, busy, forced
  );

  modport slave (
    input  in, cfg_sel, cfg_en, cfg_valid,
    output cfg_ready, out, active_sel, active_en, busy, forced
  );
endinterface

// File: rtl/console_xbar.sv
// Registered console crossbar: each output switches source only after the old line has been quiet,
// then drives an idle gap, so no UART frame in flight is ever chopped or spliced.
module console_xbar #(
  parameter int   INPUT_COUNT  = 4,
  parameter int   OUTPUT_COUNT = 4,
  parameter int   SEL_WIDTH    = 4,
  parameter int   SYNC_STAGES  = 2,
  parameter logic IDLE_LEVEL   = 1'b1,
  parameter int   QUIET_CYCLES = 16,
  parameter int   GAP_CYCLES   = 4,
  parameter int   MAX_DRAIN    = 4096
) (
  input logic          clk,
  input logic          rst,
  console_xbar_if.slave bus
);

  localparam int CW = $clog2(MAX_DRAIN + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_DRAIN,
    ST_GAP
  } state_t;

  logic [INPUT_COUNT-1:0]  sync_q [SYNC_STAGES];
  logic [INPUT_COUNT-1:0]  synced;

  state_t                  state     [OUTPUT_COUNT];
  logic [SEL_WIDTH-1:0]    act_sel   [OUTPUT_COUNT];
  logic [SEL_WIDTH-1:0]    pend_sel  [OUTPUT_COUNT];
  logic [SEL_WIDTH-1:0]    req_sel   [OUTPUT_COUNT];
  logic [CW-1:0]           quiet_cnt [OUTPUT_COUNT];
  logic [CW-1:0]           drain_cnt [OUTPUT_COUNT];
  logic [CW-1:0]           quiet_nxt [OUTPUT_COUNT];
  logic [CW-1:0]           drain_nxt [OUTPUT_COUNT];
  logic [GW-1:0]           gap_cnt   [OUTPUT_COUNT];

  logic [OUTPUT_COUNT-1:0] act_en;
  logic [OUTPUT_COUNT-1:0] pend_en;
  logic [OUTPUT_COUNT-1:0] out_q;
  logic [OUTPUT_COUNT-1:0] busy_q;
  logic [OUTPUT_COUNT-1:0] forced_q;
  logic [OUTPUT_COUNT-1:0] src_on;
  logic [OUTPUT_COUNT-1:0] src_now;
  logic [OUTPUT_COUNT-1:0] changed;
  logic [OUTPUT_COUNT*SEL_WIDTH-1:0] active_sel_flat;
  logic                    ready;
  logic                    accept;

  // Input synchroniser; resets to the idle level so a fresh channel never sees a false start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= {INPUT_COUNT{IDLE_LEVEL}};
      end
    end else begin
      sync_q[0] <= bus.in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];
  assign ready  = ~|busy_q;
  assign accept = bus.cfg_valid && ready;

  // Per-channel source decode, change detection and next counter values.
  // An out-of-range selector simply matches no input and leaves the channel off.
  always_comb begin
    src_on  = '0;
    src_now = {OUTPUT_COUNT{IDLE_LEVEL}};
    changed = '0;
    for (int k = 0; k < OUTPUT_COUNT; k++) begin
      req_sel[k] = bus.cfg_sel[k*SEL_WIDTH +: SEL_WIDTH];
      for (int i = 0; i < INPUT_COUNT; i++) begin
        if (act_en[k] && (act_sel[k] == SEL_WIDTH'(i))) begin
          src_on[k]  = 1'b1;
          src_now[k] = synced[i];
        end
      end
      changed[k]   = (bus.cfg_en[k] != act_en[k]) ||
                     (bus.cfg_en[k] && (req_sel[k] != act_sel[k]));
      quiet_nxt[k] = (src_now[k] == IDLE_LEVEL) ? (quiet_cnt[k] + CW'(1)) : '0;
      drain_nxt[k] = drain_cnt[k] + CW'(1);
    end
  end

  // Channel FSMs. A config is only taken when every channel is ACTIVE, so the whole
  // reconfiguration lands atomically; unchanged channels keep running untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= {OUTPUT_COUNT{IDLE_LEVEL}};
      busy_q   <= '0;
      forced_q <= '0;
      act_en   <= '0;
      pend_en  <= '0;
      for (int k = 0; k < OUTPUT_COUNT; k++) begin
        state[k]     <= ST_ACTIVE;
        act_sel[k]   <= '0;
        pend_sel[k]  <= '0;
        quiet_cnt[k] <= '0;
        drain_cnt[k] <= '0;
        gap_cnt[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < OUTPUT_COUNT; k++) begin
        case (state[k])
          ST_ACTIVE: begin
            out_q[k] <= src_now[k];
            if (accept) begin
              forced_q[k] <= 1'b0;
              if (changed[k]) begin
                pend_sel[k]  <= req_sel[k];
                pend_en[k]   <= bus.cfg_en[k];
                quiet_cnt[k] <= '0;
                drain_cnt[k] <= '0;
                gap_cnt[k]   <= '0;
                busy_q[k]    <= 1'b1;
                state[k]     <= src_on[k] ? ST_DRAIN : ST_GAP;
              end
            end
          end
          ST_DRAIN: begin
            out_q[k]     <= src_now[k];
            quiet_cnt[k] <= quiet_nxt[k];
            drain_cnt[k] <= drain_nxt[k];
            if (quiet_nxt[k] == CW'(QUIET_CYCLES)) begin
              state[k] <= ST_GAP;
            end else if (drain_nxt[k] == CW'(MAX_DRAIN)) begin
              state[k]    <= ST_GAP;
              forced_q[k] <= 1'b1;
            end
          end
          ST_GAP: begin
            out_q[k]   <= IDLE_LEVEL;
            gap_cnt[k] <= gap_cnt[k] + GW'(1);
            if (gap_cnt[k] == GW'(GAP_CYCLES - 1)) begin
              act_sel[k] <= pend_sel[k];
              act_en[k]  <= pend_en[k];
              busy_q[k]  <= 1'b0;
              state[k]   <= ST_ACTIVE;
            end
          end
          default: begin
            state[k] <= ST_ACTIVE;
          end
        endcase
      end
    end
  end

  always_comb begin
    active_sel_flat = '0;
    for (int k = 0; k < OUTPUT_COUNT; k++) begin
      active_sel_flat[k*SEL_WIDTH +: SEL_WIDTH] = act_sel[k];
    end
  end

  assign bus.cfg_ready  = ready;
  assign bus.out        = out_q;
  assign bus.active_sel = active_sel_flat;
  assign bus.active_en  = act_en;
  assign bus.busy       = busy_q;
  assign bus.forced     = forced_q;

endmodule

// File: tb/tb_console_xbar.sv
// Scoreboarded bench for console_xbar: a timestamp-based channel model predicts every cycle's
// outputs into a queue, and a negedge monitor pops and compares against the DUT.
module tb_console_xbar;

  localparam int   IC   = 4;
  localparam int   OC   = 4;
  localparam int   SW   = 4;
  localparam int   SYNC = 2;
  localparam logic IDLE = 1'b1;
  localparam int   Q    = 4;
  localparam int   G    = 2;
  localparam int   MAXD = 32;

  localparam int M_FOLLOW = 0;
  localparam int M_DRAIN  = 1;
  localparam int M_GAP    = 2;

  typedef struct {
    int             edge_n;
    logic [OC-1:0]  out_v;
    logic [OC-1:0]  busy_v;
    logic [OC*SW-1:0] asel_v;
    logic [OC-1:0]  aen_v;
    logic [OC-1:0]  forced_v;
    logic           ready_v;
  } exp_t;

  logic clk;
  logic rst;

  console_xbar_if #(.INPUT_COUNT(IC), .OUTPUT_COUNT(OC), .SEL_WIDTH(SW)) bus ();

  console_xbar #(
    .INPUT_COUNT (IC),
    .OUTPUT_COUNT(OC),
    .SEL_WIDTH   (SW),
    .SYNC_STAGES (SYNC),
    .IDLE_LEVEL  (IDLE),
    .QUIET_CYCLES(Q),
    .GAP_CYCLES  (G),
    .MAX_DRAIN   (MAXD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic            cur_rst;
  logic [IC-1:0]   cur_in;
  logic [OC*SW-1:0] cur_sel;
  logic [OC-1:0]   cur_en;
  logic            cur_valid;
  bit              acc_last;

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];

  // Model: each channel is following a line, draining since some edge, or gapping since some edge.
  logic [IC-1:0] x_at [int];
  int edge_n     = 0;
  int valid_from = 0;
  int m_mode  [OC];
  int m_asel  [OC];
  bit m_aen   [OC];
  int m_psel  [OC];
  bit m_pen   [OC];
  int m_t0    [OC];
  int m_tlast [OC];
  int m_tgap  [OC];
  bit m_forced[OC];

  function automatic logic [OC*SW-1:0] pack_sel(int s0, int s1, int s2, int s3);
    return {SW'(s3), SW'(s2), SW'(s1), SW'(s0)};
  endfunction

  function automatic logic synced_at(int e, int src);
    if ((e - SYNC) < valid_from || !x_at.exists(e - SYNC)) return IDLE;
    return x_at[e - SYNC][src];
  endfunction

  function automatic bit model_on(int k);
    return m_aen[k] && (m_asel[k] < IC);
  endfunction

  function automatic bit model_ready();
    for (int k = 0; k < OC; k++) if (m_mode[k] != M_FOLLOW) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    exp_t x;
    logic [OC-1:0] ob;
    logic [SW-1:0] rs;
    bit re;
    bit acc;
    edge_n++;
    x_at[edge_n] = cur_in;
    acc_last = 1'b0;
    if (cur_rst) begin
      for (int k = 0; k < OC; k++) begin
        m_mode[k] = M_FOLLOW; m_asel[k] = 0; m_aen[k] = 1'b0; m_forced[k] = 1'b0;
      end
      valid_from = edge_n + 1;
      ob = {OC{IDLE}};
    end else begin
      acc = cur_valid && model_ready();
      acc_last = acc;
      for (int k = 0; k < OC; k++)
        ob[k] = (m_mode[k] != M_GAP && model_on(k)) ? synced_at(edge_n, m_asel[k]) : IDLE;
      for (int k = 0; k < OC; k++) begin
        rs = cur_sel[k*SW +: SW];
        re = cur_en[k];
        case (m_mode[k])
          M_FOLLOW: if (acc) begin
            m_forced[k] = 1'b0;
            if (re != m_aen[k] || (re && int'(rs) != m_asel[k])) begin
              m_psel[k] = int'(rs);
              m_pen[k]  = re;
              if (model_on(k)) begin
                m_mode[k] = M_DRAIN; m_t0[k] = edge_n; m_tlast[k] = edge_n;
              end else begin
                m_mode[k] = M_GAP; m_tgap[k] = edge_n;
              end
            end
          end
          M_DRAIN: begin
            if (synced_at(edge_n, m_asel[k]) != IDLE) m_tlast[k] = edge_n;
            if (edge_n - m_tlast[k] >= Q) begin
              m_mode[k] = M_GAP; m_tgap[k] = edge_n;
            end else if (edge_n - m_t0[k] >= MAXD) begin
              m_mode[k] = M_GAP; m_tgap[k] = edge_n; m_forced[k] = 1'b1;
            end
          end
          default: if (edge_n - m_tgap[k] >= G) begin
            m_asel[k] = m_psel[k]; m_aen[k] = m_pen[k]; m_mode[k] = M_FOLLOW;
          end
        endcase
      end
    end
    x.edge_n = edge_n;
    x.out_v  = ob;
    for (int k = 0; k < OC; k++) begin
      x.busy_v[k]           = (m_mode[k] != M_FOLLOW);
      x.asel_v[k*SW +: SW]  = SW'(m_asel[k]);
      x.aen_v[k]            = m_aen[k];
      x.forced_v[k]         = m_forced[k];
    end
    x.ready_v = model_ready();
    exp_q.push_back(x);
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    rst           = cur_rst;
    bus.in        = cur_in;
    bus.cfg_sel   = cur_sel;
    bus.cfg_en    = cur_en;
    bus.cfg_valid = cur_valid;
    @(posedge clk);
    model_step();
    if (acc_last) cur_valid = 1'b0;
  endtask

  task automatic cmp(string name, int e, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %h, expected %h", name, e, got, want);
    end
  endtask

  task automatic checkOutput(exp_t x);
    cmp("out",        x.edge_n, 32'(bus.out),        32'(x.out_v));
    cmp("busy",       x.edge_n, 32'(bus.busy),       32'(x.busy_v));
    cmp("active_sel", x.edge_n, 32'(bus.active_sel), 32'(x.asel_v));
    cmp("active_en",  x.edge_n, 32'(bus.active_en),  32'(x.aen_v));
    cmp("forced",     x.edge_n, 32'(bus.forced),     32'(x.forced_v));
    cmp("cfg_ready",  x.edge_n, 32'(bus.cfg_ready),  32'(x.ready_v));
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  task automatic submit_cfg(logic [OC*SW-1:0] s, logic [OC-1:0] en);
    cur_sel   = s;
    cur_en    = en;
    cur_valid = 1'b1;
  endtask

  task automatic run_idle(int n, logic [IC-1:0] v);
    repeat (n) begin
      cur_in = v;
      applyStimulus();
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while ((cur_valid || !model_ready()) && n < 300) begin
      cur_in = '1;
      applyStimulus();
      n++;
    end
    if (cur_valid || !model_ready()) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_ready: config still pending after %0d cycles", n);
    end
  endtask

  initial begin
    cur_rst = 1'b1; cur_in = 4'b1010; cur_sel = '0; cur_en = '0; cur_valid = 1'b0;
    rst = 1'b1; bus.in = cur_in; bus.cfg_sel = '0; bus.cfg_en = '0; bus.cfg_valid = 1'b0;

    run_idle(3, 4'b1010);
    cur_rst = 1'b0;
    run_idle(4, 4'b1010);
    run_idle(3, 4'b1111);

    // Channel 0 is off, so enabling it on line 2 goes straight to the gap.
    submit_cfg(pack_sel(2, 0, 0, 0), 4'b0001);
    run_idle(6, 4'b1111);
    for (int c = 0; c < 12; c++) begin
      cur_in = 4'b1111;
      cur_in[2] = c[0];
      applyStimulus();
    end
    run_idle(4, 4'b1111);

    // Move channel 0 to line 3 while line 2 is still chattering; a second request waits on busy.
    submit_cfg(pack_sel(3, 0, 0, 0), 4'b0001);
    for (int c = 0; c < 45; c++) begin
      cur_in = 4'b1111;
      if (c < 18) cur_in[2] = ((c / 3) % 2) == 1;
      if (c >= 32) cur_in[3] = c[0];
      if (c == 2) submit_cfg(pack_sel(3, 0, 0, 0), 4'b0011);
      applyStimulus();
    end
    wait_ready();

    // Old source stuck low: the drain can only end by timeout.
    submit_cfg(pack_sel(2, 0, 0, 0), 4'b0011);
    run_idle(45, 4'b0111);
    run_idle(2, 4'b1111);
    submit_cfg(pack_sel(2, 0, 0, 0), 4'b0011);
    run_idle(3, 4'b1111);

    // Out-of-range selector on channel 1, then the identical config again.
    submit_cfg(pack_sel(2, 7, 0, 0), 4'b0011);
    run_idle(12, 4'b1111);
    submit_cfg(pack_sel(2, 7, 0, 0), 4'b0011);
    run_idle(3, 4'b1111);

    for (int c = 0; c < 300; c++) begin
      for (int b = 0; b < IC; b++) cur_in[b] = ($urandom_range(0, 99) < 85);
      if (!cur_valid && $urandom_range(0, 99) < 10)
        submit_cfg(pack_sel($urandom_range(0, 7), $urandom_range(0, 7),
                            $urandom_range(0, 7), $urandom_range(0, 7)),
                   OC'($urandom_range(0, 15)));
      applyStimulus();
    end
    wait_ready();

    // Reset in the middle of a gap drops the pending config.
    submit_cfg(pack_sel(0, 0, 0, 0), 4'b0000);
    wait_ready();
    submit_cfg(pack_sel(1, 1, 1, 1), 4'b1111);
    run_idle(2, 4'b1111);
    cur_rst = 1'b1;
    run_idle(1, 4'b1111);
    cur_rst = 1'b0;
    run_idle(6, 4'b1111);

    repeat (2) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
